sa_skew_feeder: RTL

SA_SKEW_FEEDER -- requirements
Module: sa_skew_feeder

---
 rtl/sa_pkg.sv | 22 ++
 rtl/skew_delay_line.sv | 43 ++++
 rtl/sa_skew_feeder.sv | 119 +++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic-array skew feeder.
//   DEF_WIDTH : default operand width in bits
//   DEF_N     : default number of array lanes (square array, N x N)
//   DEF_DRAIN : default number of zero-fill cycles after the last vector
//   state_t   : feeder frame-control states
// -----------------------------------------------------------------------------
package sa_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N     = 64;
    localparam int DEF_DRAIN = 2 * DEF_N - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/skew_delay_line.sv
// -----------------------------------------------------------------------------
// skew_delay_line
// Fixed-length shift register used to skew one lane of the operand stream.
// The output is the input value from exactly DEPTH cycles earlier.
//   CLK   : rising-edge clock
//   RST   : asynchronous active-high reset, clears every stage
//   d_in  : lane data entering the line (zero when there is no beat)
//   d_out : lane data delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module skew_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // The line shifts every cycle; the array has no stall path.
    always_comb begin
        stage_d[0] = d_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// -----------------------------------------------------------------------------
// sa_skew_feeder
// Turns unskewed A/B operand vectors into the diagonal wavefront expected by a
// 2D systolic array: lane n is delayed by n+1 cycles. After the last vector of
// a frame the lines are flushed with zeros for DRAIN cycles, then done pulses.
//   CLK, RST      : clock, asynchronous active-high reset
//   in_valid      : beat on in_a/in_b/in_last is valid
//   in_ready      : a beat can be accepted this cycle (IDLE or STREAM)
//   in_a, in_b    : unskewed vectors, lane n at [(n+1)*WIDTH-1 : n*WIDTH]
//   in_last       : final vector of the frame
//   AA, BB        : skewed streams to the array, same lane packing
//   busy          : frame in progress (STREAM or FLUSH)
//   done          : one-cycle pulse after the drain completes
// -----------------------------------------------------------------------------
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int DRAIN = 2 * N - 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH*N-1:0] in_a,
    input  logic [WIDTH*N-1:0] in_b,
    input  logic               in_last,
    output logic [WIDTH*N-1:0] AA,
    output logic [WIDTH*N-1:0] BB,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic [WIDTH*N-1:0] lane_in_a, lane_in_b;

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_STREAM);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == ST_STREAM) || (state_q == ST_FLUSH);
    assign done     = (state_q == ST_DONE);

    // Cycles without an accepted beat inject zeros, which also provides the
    // zero fill during FLUSH and keeps A/B aligned through bubbles.
    assign lane_in_a = accept ? in_a : '0;
    assign lane_in_b = accept ? in_b : '0;

    // Frame control: the drain counter runs only in FLUSH and is cleared on
    // every entry to FLUSH so each frame drains for exactly DRAIN cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = in_last ? ST_FLUSH : ST_STREAM;
                    cnt_d   = '0;
                end
            end
            ST_STREAM: begin
                if (accept && in_last) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == CNT_W'(DRAIN - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lane n of A and B share the same depth so pairs arrive together.
    for (genvar n = 0; n < N; n++) begin : g_lane
        skew_delay_line #(
            .WIDTH (WIDTH),
            .DEPTH (n + 1)
        ) u_dly_a (
            .CLK   (CLK),
            .RST   (RST),
            .d_in  (lane_in_a[n*WIDTH +: WIDTH]),
            .d_out (AA[n*WIDTH +: WIDTH])
        );

        skew_delay_line #(
            .WIDTH (WIDTH),
            .DEPTH (n + 1)
        ) u_dly_b (
            .CLK   (CLK),
            .RST   (RST),
            .d_in  (lane_in_b[n*WIDTH +: WIDTH]),
            .d_out (BB[n*WIDTH +: WIDTH])
        );
    end

endmodule
